// File: rtl/xex_bridge_pkg.sv
// Shared types and constants for the xexaes256 block bridge.
// Provides engine mode encodings, block/word types, the word count per
// block and a byte-reversal helper used when XEX_BYTE_SWAP_EN is defined.
package xex_bridge_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_ENC  = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    // Little-endian bus word to big-endian engine word (and back).
    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/xex_block_fifo.sv
// Result FIFO for the block bridge: DEPTH entries of 128-bit blocks.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset (pointers/count)
//   wr_en/wr_data push one block
//   rd_en         pop the head block (caller guarantees non-empty)
//   rd_data       head block, combinational read
//   count         current occupancy, 0..DEPTH
module xex_block_fifo
    import xex_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en,
    input  block_t           wr_data,
    input  logic             rd_en,
    output block_t           rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    block_t           mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Credit-based issue upstream makes these unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (!n_rst)
        !(wr_en && !rd_en && count_q == CNT_W'(DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!n_rst)
        !(rd_en && count_q == '0));

endmodule

// File: rtl/xex_block_bridge.sv
// Word-level bridge between the 32-bit bus controller and the xexaes256
// engine. Packs four write words (MSB-first) into a 128-bit block, issues it
// with credit so results are never dropped, buffers results and returns them
// as four MSB-first read words.
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   cfg_mode                   requested engine mode, sampled only when idle
//   wr_valid/wr_ready/wr_data  write word stream
//   rd_valid/rd_ready/rd_data  read word stream
//   eng_*                      engine block handshake, mode and results
//   idle                       nothing partial, in flight or buffered
//   err_unexp                  sticky: result arrived with nothing in flight
// Build option: XEX_BYTE_SWAP_EN byte-reverses every word on ingress/egress.
//
// state    | meaning
// ST_FILL  | collecting write words into the block register
// ST_ISSUE | block complete, offered to engine once credit is available
module xex_block_bridge
    import xex_bridge_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [1:0]   cfg_mode,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [31:0]  wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [31:0]  rd_data,
    output logic         eng_in_rdy,
    output logic [127:0] eng_data_in,
    output logic [1:0]   eng_mode,
    input  logic         eng_busy,
    input  logic         eng_out_rdy,
    input  logic [127:0] eng_data_out,
    output logic         idle,
    output logic         err_unexp
);

    typedef enum logic {ST_FILL = 1'b0, ST_ISSUE = 1'b1} state_t;

    localparam logic [CNT_W:0] DEPTH_C  = (CNT_W+1)'(OUT_DEPTH);
    localparam logic [1:0]     LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

    state_t           state_q, state_d;
    logic [1:0]       word_idx_q, word_idx_d;
    logic [1:0]       rd_idx_q, rd_idx_d;
    block_t           block_q, block_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count, fifo_count_d;
    logic [1:0]       eng_mode_q, eng_mode_d;
    logic             wr_ready_q, wr_ready_d;
    logic             eng_in_rdy_q, eng_in_rdy_d;
    logic             idle_q, idle_d;
    logic             err_q, err_d;

    word_t  wr_word, head_word;
    block_t fifo_head;
    logic   wr_fire, eng_accept, res_valid, rd_fire, pop;

`ifdef XEX_BYTE_SWAP_EN
    assign wr_word = byte_swap(wr_data);
    assign rd_data = byte_swap(head_word);
`else
    assign wr_word = wr_data;
    assign rd_data = head_word;
`endif

    assign wr_fire    = wr_valid && wr_ready_q;
    assign eng_accept = eng_in_rdy_q && !eng_busy;
    // A result with nothing in flight is flagged and discarded.
    assign res_valid  = eng_out_rdy && (inflight_q != '0);
    assign rd_valid   = (fifo_count != '0);
    assign rd_fire    = rd_valid && rd_ready;
    assign pop        = rd_fire && (rd_idx_q == LAST_IDX);

    xex_block_fifo #(
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (res_valid),
        .wr_data (eng_data_out),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count)
    );

    always_comb begin
        case (rd_idx_q)
            2'd0:    head_word = fifo_head[127:96];
            2'd1:    head_word = fifo_head[95:64];
            2'd2:    head_word = fifo_head[63:32];
            default: head_word = fifo_head[31:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        block_d    = block_q;
        case (state_q)
            ST_FILL: begin
                if (wr_fire) begin
                    case (word_idx_q)
                        2'd0:    block_d[127:96] = wr_word;
                        2'd1:    block_d[95:64]  = wr_word;
                        2'd2:    block_d[63:32]  = wr_word;
                        default: block_d[31:0]   = wr_word;
                    endcase
                    if (word_idx_q == LAST_IDX) begin
                        word_idx_d = '0;
                        state_d    = ST_ISSUE;
                    end else begin
                        word_idx_d = word_idx_q + 2'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (eng_accept) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase

        inflight_d = inflight_q;
        case ({eng_accept, res_valid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        fifo_count_d = fifo_count;
        case ({res_valid, pop})
            2'b10:   fifo_count_d = fifo_count + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count - CNT_W'(1);
            default: fifo_count_d = fifo_count;
        endcase

        rd_idx_d = rd_fire ? rd_idx_q + 2'd1 : rd_idx_q;
        err_d    = err_q || (eng_out_rdy && inflight_q == '0);

        // Outputs are registered from next-state values so credit seen by
        // the engine already accounts for this cycle's accept/result/pop.
        wr_ready_d   = (state_d == ST_FILL);
        eng_in_rdy_d = (state_d == ST_ISSUE) &&
                       (({1'b0, fifo_count_d} + {1'b0, inflight_d}) < DEPTH_C);
        idle_d       = (state_d == ST_FILL) && (word_idx_d == '0) &&
                       (inflight_d == '0) && (fifo_count_d == '0);
        eng_mode_d   = idle_q ? cfg_mode : eng_mode_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_FILL;
            word_idx_q   <= '0;
            rd_idx_q     <= '0;
            block_q      <= '0;
            inflight_q   <= '0;
            eng_mode_q   <= MODE_IDLE;
            wr_ready_q   <= 1'b0;
            eng_in_rdy_q <= 1'b0;
            idle_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            rd_idx_q     <= rd_idx_d;
            block_q      <= block_d;
            inflight_q   <= inflight_d;
            eng_mode_q   <= eng_mode_d;
            wr_ready_q   <= wr_ready_d;
            eng_in_rdy_q <= eng_in_rdy_d;
            idle_q       <= idle_d;
            err_q        <= err_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign eng_in_rdy  = eng_in_rdy_q;
    assign eng_data_in = block_q;
    assign eng_mode    = eng_mode_q;
    assign idle        = idle_q;
    assign err_unexp   = err_q;

endmodule

// File: doc/xex_block_bridge.md
Name: xex_block_bridge

Overview:
- Word-level bridge between the 32-bit bus controller and the xexaes256 engine.
- Accumulates four 32-bit write words into one 128-bit block and issues it to the engine over its in_rdy/busy handshake.
- Captures each engine result, presented on out_rdy, into a result FIFO and serialises it back into four 32-bit read words.
- Applies credit-based issue so no engine result is ever dropped; the engine has no output backpressure.

Parameters:
- OUT_DEPTH, 4: result FIFO depth in 128-bit blocks; power of two, ≥2.
- CNT_W, 3: width of the in-flight and FIFO occupancy counters; equals $clog2(OUT_DEPTH)+1.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  requested engine mode (2'b10 encrypt, 2'b11 decrypt, 2'b00 idle)
- wr_valid  in  1  write word valid
- wr_ready  out  1  write word accepted when wr_valid&&wr_ready at posedge
- wr_data  in  32  write word
- rd_valid  out  1  read word valid
- rd_ready  in  1  read word consumed when rd_valid&&rd_ready at posedge
- rd_data  out  32  read word
- eng_in_rdy  out  1  block on eng_data_in is offered to the engine
- eng_data_in  out  128  block to engine
- eng_mode  out  2  mode driven to engine
- eng_busy  in  1  engine busy; a block is accepted at a posedge with eng_in_rdy=1 and eng_busy=0
- eng_out_rdy  in  1  one-cycle pulse: eng_data_out valid
- eng_data_out  in  128  engine result
- idle  out  1  no partial block, no in-flight block, result FIFO empty
- err_unexp  out  1  sticky: eng_out_rdy seen while in-flight count was 0

Behaviour:
- Reset: all counters, the FIFO, word indices and err_unexp clear; wr_ready=0 for the reset cycle, then 1; rd_valid=0, eng_in_rdy=0, eng_data_in=0, eng_mode=2'b00, idle=1.
- Reset mid-operation discards partial blocks, in-flight accounting and FIFO contents. Late eng_out_rdy pulses arriving after reset set err_unexp.
- Word order: first word of a block goes to [127:96], fourth to [31:0]. Read words use the same MSB-first order.
- Input FSM:
  - FILL: wr_ready=1; each accepted word writes slot word_idx; word_idx++. After the 4th word go to ISSUE.
  - ISSUE: wr_ready=0; eng_in_rdy=1 only when credit>0, with credit = OUT_DEPTH − fifo_count − inflight. eng_data_in is held stable.
  - On accept: inflight++, return to FILL with word_idx=0.
- Accept to refill: zero bubble; the first word of the next block can be accepted the cycle after accept.
- In-flight accounting: inflight-- on eng_out_rdy. Simultaneous accept and eng_out_rdy leaves inflight unchanged.
- eng_out_rdy with inflight=0: result dropped, err_unexp set, no FIFO write.
- Result FIFO: written on every valid eng_out_rdy. The credit rule guarantees it is never full at a write; an overflow write is a design bug (assertion).
- Read side:
  - rd_valid = fifo non-empty; rd_data = head word [rd_idx].
  - Each handshake increments rd_idx. On the 4th, the head is popped and rd_idx wraps to 0.
  - A same-cycle write and pop is legal; fifo_count is unchanged.
- Latency: engine result to rd_valid is one cycle (registered FIFO write, combinational head read).
- Mode: eng_mode loads cfg_mode only in a cycle where idle=1; otherwise it holds. Changing cfg_mode mid-stream therefore takes effect after drain.
- idle is registered from the next-state values.

Optional Feature:
- Macro: XEX_BYTE_SWAP_EN.
- Defined: each 32-bit word is byte-reversed on both wr_data ingress and rd_data egress (little-endian bus to big-endian engine block).
- Undefined: words pass unmodified.

Decomposition:
- Package xex_bridge_pkg: mode constants MODE_IDLE=2'b00, MODE_ENC=2'b10, MODE_DEC=2'b11; typedef block_t (logic [127:0]); typedef word_t (logic [31:0]); WORDS_PER_BLOCK=4.
- One sub-module, xex_block_fifo: parametrised OUT_DEPTH×128 synchronous FIFO with count output. Assembler, credit logic and serialiser stay in the top level.

Test Plan:
- Reset, then write words 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff with cfg_mode=2'b10 -> eng_data_in=128'h00112233445566778899aabbccddeeff with eng_in_rdy=1 the next cycle; eng_mode=2'b10.
- Hold eng_busy=1 for 10 cycles after a block is assembled -> eng_in_rdy stays 1, eng_data_in stable, wr_ready=0; accept on the first cycle with eng_busy=0.
- Hold rd_ready=0, stream 6 blocks with the engine returning each 3 cycles after accept -> exactly 4 blocks accepted, eng_in_rdy=0 afterwards, no err_unexp. Releasing rd_ready drains 24 words in order.
- Pulse eng_out_rdy with no block issued -> err_unexp=1 and stays 1 until n_rst, rd_valid remains 0.
- Assert n_rst low after 2 words of a block and with 1 block in the FIFO -> rd_valid=0, idle=1, wr_ready=0 during reset. The next 4 words after release form a fresh block.
- With XEX_BYTE_SWAP_EN, write 32'h00112233 as the first word -> eng_data_in[127:96]=32'h33221100, and a returned 128'h33221100… yields rd_data 32'h00112233.
